ptr_data_fetch: RTL and testbench

// - Consumer of the traversal pointer stream (out_ptr/out_ptr_vld) from the linked-list walker.
// - Per valid non-null pointer: reads the node payload from a local n-entry data RAM.
// - Buffers {ptr, data} in a FIFO and presents it on a valid/ready output.
// - The walker has no backpressure input: this block must accept every beat. Overflow drops the beat and flags it.

---
 rtl/list_pkg.sv | 7 +
 rtl/ptr_data_fetch_chk.sv | 25 ++
 rtl/ptr_data_fifo.sv | 61 ++++++
 rtl/ptr_data_fetch.sv | 113 +++++++++++
 tb/tb_ptr_data_fetch.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/list_pkg.sv
// Shared linked-list definitions: node count, pointer width and pointer type.
// The walker and every pointer consumer import this package.
package list_pkg;
  parameter int n = 16;
  localparam int w_ptr = $clog2(n);
  typedef logic [w_ptr-1:0] ptr_t;
endpackage

// File: rtl/ptr_data_fetch_chk.sv
// Occupancy checker: FIFO count must equal accepted pushes minus pops since reset.
module ptr_data_fetch_chk #(
  parameter int DEPTH = 4,
  parameter int W_CNT = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst,
  input logic             i_push_ok,
  input logic             i_pop_ok,
  input logic [W_CNT-1:0] i_count
);
  logic [31:0] r_occ;

  // Independent reference occupancy built from handshake events.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= 32'd0;
    end else begin
      r_occ <= r_occ + {31'd0, i_push_ok} - {31'd0, i_pop_ok};
    end
  end

  a_occ : assert property (@(posedge clk) disable iff (!rst) 32'(i_count) == r_occ);
  a_max : assert property (@(posedge clk) disable iff (!rst) 32'(i_count) <= 32'(DEPTH));
endmodule

// File: rtl/ptr_data_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is still
// accepted when a pop frees a slot on the same edge.
module ptr_data_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12,
  parameter int W_CNT = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_din,
  input  logic             i_pop,
  output logic [W-1:0]     o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [W_CNT-1:0] o_count,
  output logic             o_push_ok,
  output logic             o_pop_ok
);
  localparam int W_IDX = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [W_IDX-1:0] r_wr_idx;
  logic [W_IDX-1:0] r_rd_idx;
  logic [W_CNT-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == W_CNT'(DEPTH));
  assign o_empty   = (r_count == W_CNT'(0));
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_push_ok = w_push_ok;
  assign o_pop_ok  = w_pop_ok;
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_idx];

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_idx] <= i_din;
    end
  end

  // Indices wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_idx <= W_IDX'(0);
      r_rd_idx <= W_IDX'(0);
      r_count  <= W_CNT'(0);
    end else begin
      if (w_push_ok) r_wr_idx <= r_wr_idx + W_IDX'(1);
      if (w_pop_ok)  r_rd_idx <= r_rd_idx + W_IDX'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + W_CNT'(1);
        2'b01:   r_count <= r_count - W_CNT'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ptr_data_fetch.sv
// Fetches the node payload for each non-null walker pointer and queues
// {ptr, data} for a valid/ready consumer; beats that find no room are dropped.
module ptr_data_fetch
  import list_pkg::*;
#(
  parameter int W_DATA = 8,
  parameter int DEPTH  = 4,
  parameter int W_CNT  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  ptr_t              in_ptr,
  input  logic              in_vld,
  input  logic              wr_en,
  input  ptr_t              wr_addr,
  input  logic [W_DATA-1:0] wr_data,
  output ptr_t              out_ptr,
  output logic [W_DATA-1:0] out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [W_CNT-1:0]  count,
  output logic              ovf,
  input  logic              clr_ovf,
  output logic [7:0]        drop_cnt
);
  localparam int W_FIFO = w_ptr + W_DATA;

  logic [W_DATA-1:0] r_ram [n];
  logic [W_DATA-1:0] r_rdata;
  ptr_t              r_s1_ptr;
  logic              r_s1_vld;
  logic              r_ovf;
  logic [7:0]        r_drop_cnt;
  logic              w_take;
  logic              w_empty;
  logic              w_full;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic              w_drop;
  logic [W_FIFO-1:0] w_head;

  assign w_take = in_vld & (in_ptr != ptr_t'(0));
  assign w_drop = r_s1_vld & ~w_push_ok;

  // Payload RAM: nonblocking read and write on one edge give read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_ram[wr_addr] <= wr_data;
    end
    if (w_take) begin
      r_rdata <= r_ram[in_ptr];
    end
  end

  // Stage S1 pointer/valid; null pointers never enter the pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld <= 1'b0;
      r_s1_ptr <= ptr_t'(0);
    end else begin
      r_s1_vld <= w_take;
      if (w_take) r_s1_ptr <= in_ptr;
    end
  end

  ptr_data_fifo #(.DEPTH(DEPTH), .W(W_FIFO), .W_CNT(W_CNT)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (r_s1_vld),
    .i_din    ({r_s1_ptr, r_rdata}),
    .i_pop    (out_rdy),
    .o_dout   (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (count),
    .o_push_ok(w_push_ok),
    .o_pop_ok (w_pop_ok)
  );

  // Sticky overflow and saturating drop counter; a drop beats a same-edge clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_ovf      <= 1'b1;
      r_drop_cnt <= clr_ovf ? 8'd1 : ((r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1);
    end else if (clr_ovf) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_ovf      <= r_ovf;
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign out_vld  = ~w_empty;
  assign out_ptr  = w_head[W_FIFO-1:W_DATA];
  assign out_data = w_head[W_DATA-1:0];
  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;

  ptr_data_fetch_chk #(.DEPTH(DEPTH), .W_CNT(W_CNT)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .i_push_ok(w_push_ok),
    .i_pop_ok (w_pop_ok),
    .i_count  (count)
  );

  logic w_unused;
  assign w_unused = w_full;
endmodule

// File: tb/tb_ptr_data_fetch.sv
// Directed bench for ptr_data_fetch: inputs change after the falling edge,
// outputs are sampled on the falling edge.
module tb_ptr_data_fetch;
  import list_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  ptr_t       in_ptr;
  logic       in_vld;
  logic       wr_en;
  ptr_t       wr_addr;
  logic [7:0] wr_data;
  ptr_t       out_ptr;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic [2:0] count;
  logic       ovf;
  logic       clr_ovf;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ptr_data_fetch dut (
    .clk(clk), .rst(rst), .in_ptr(in_ptr), .in_vld(in_vld),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_ptr(out_ptr), .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .count(count), .ovf(ovf), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
  );

  task automatic wr(input int addr, input logic [7:0] data);
    wr_en = 1'b1; wr_addr = ptr_t'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_vld = 1'b0; in_ptr = 4'd0; wr_en = 1'b0; wr_addr = 4'd0;
    wr_data = 8'd0; out_rdy = 1'b0; clr_ovf = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (out_vld !== 1'b0 || count !== 3'd0 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: vld=%b count=%0d ovf=%b drop=%0d, need 0/0/0/0", out_vld, count, ovf, drop_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_in_order();
    ptr_t       ptrs [3] = '{4'd7, 4'd15, 4'd8};
    logic [7:0] dats [3] = '{8'hA7, 8'hAF, 8'hA8};
    wr(7, 8'hA7); wr(15, 8'hAF); wr(8, 8'hA8);
    out_rdy = 1'b1;
    in_ptr = 4'd7; in_vld = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_fail++; $display("FAIL latency_t1: out_vld=%b need 0", out_vld);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin in_ptr = ptrs[i+1]; in_vld = 1'b1; end
      else in_vld = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_vld !== 1'b1 || out_ptr !== ptrs[i] || out_data !== dats[i] || count !== 3'd1) begin
        n_fail++;
        $display("FAIL in_order[%0d]: vld=%b ptr=%0d data=%h count=%0d, need 1/%0d/%h/1",
                 i, out_vld, out_ptr, out_data, count, ptrs[i], dats[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_vld !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL in_order_empty: vld=%b count=%0d need 0/0", out_vld, count);
    end
  endtask

  task automatic test_overflow();
    for (int p = 9; p <= 14; p++) wr(p, 8'(8'hC0 + p));
    out_rdy = 1'b0;
    for (int p = 9; p <= 14; p++) begin
      in_ptr = ptr_t'(p); in_vld = 1'b1;
      @(negedge clk);
    end
    in_vld = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (count !== 3'd4 || ovf !== 1'b1 || drop_cnt !== 8'd2) begin
      n_fail++; $display("FAIL overflow: count=%0d ovf=%b drop=%0d need 4/1/2", count, ovf, drop_cnt);
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_vld !== 1'b1 || out_ptr !== ptr_t'(9 + i) || out_data !== 8'(8'hC9 + i)) begin
        n_fail++;
        $display("FAIL overflow_drain[%0d]: vld=%b ptr=%0d data=%h need 1/%0d/%h",
                 i, out_vld, out_ptr, out_data, 9 + i, 8'(8'hC9 + i));
      end
      @(negedge clk);
    end
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_fail++; $display("FAIL overflow_empty: out_vld=%b need 0", out_vld);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    n_checks++;
    if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL clr_ovf: ovf=%b drop=%0d need 0/0", ovf, drop_cnt);
    end
  endtask

  task automatic test_full_push_pop();
    ptr_t exp_p [4] = '{4'd2, 4'd3, 4'd4, 4'd3};
    for (int p = 1; p <= 4; p++) wr(p, 8'(8'hB0 + p));
    out_rdy = 1'b0;
    for (int p = 1; p <= 4; p++) begin
      in_ptr = ptr_t'(p); in_vld = 1'b1;
      @(negedge clk);
    end
    in_vld = 1'b0;
    @(negedge clk); @(negedge clk);
    in_ptr = 4'd3; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0; out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    n_checks++;
    if (count !== 3'd4 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL full_push_pop: count=%0d ovf=%b drop=%0d need 4/0/0", count, ovf, drop_cnt);
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_vld !== 1'b1 || out_ptr !== exp_p[i] || out_data !== 8'(8'hB0 + exp_p[i])) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: vld=%b ptr=%0d data=%h need 1/%0d/%h",
                 i, out_vld, out_ptr, out_data, exp_p[i], 8'(8'hB0 + exp_p[i]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_null_ptr();
    ptr_t seq [5] = '{4'd0, 4'd2, 4'd0, 4'd4, 4'd0};
    int   seen = 0;
    wr(2, 8'h22); wr(4, 8'h44);
    out_rdy = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 5) begin in_ptr = seq[c]; in_vld = 1'b1; end
      else in_vld = 1'b0;
      @(negedge clk);
      if (out_vld === 1'b1) begin
        n_checks++;
        if ((seen == 0 && (out_ptr !== 4'd2 || out_data !== 8'h22)) ||
            (seen == 1 && (out_ptr !== 4'd4 || out_data !== 8'h44)) || seen > 1) begin
          n_fail++;
          $display("FAIL null_ptr_beat[%0d]: ptr=%0d data=%h unexpected", seen, out_ptr, out_data);
        end
        seen++;
      end
    end
    n_checks++;
    if (seen != 2 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL null_ptr_total: beats=%0d drop=%0d need 2/0", seen, drop_cnt);
    end
  endtask

  task automatic test_read_first();
    wr(5, 8'h11);
    out_rdy = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h55; in_ptr = 4'd5; in_vld = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    in_vld = 1'b0;
    n_checks++;
    if (out_vld !== 1'b1 || out_ptr !== 4'd5 || out_data !== 8'h11) begin
      n_fail++; $display("FAIL read_first_old: vld=%b ptr=%0d data=%h need 1/5/11", out_vld, out_ptr, out_data);
    end
    @(negedge clk);
    n_checks++;
    if (out_vld !== 1'b1 || out_ptr !== 4'd5 || out_data !== 8'h55) begin
      n_fail++; $display("FAIL read_first_new: vld=%b ptr=%0d data=%h need 1/5/55", out_vld, out_ptr, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    out_rdy = 1'b0;
    for (int p = 2; p <= 5; p++) begin
      in_ptr = ptr_t'(p); in_vld = 1'b1;
      @(negedge clk);
    end
    in_vld = 1'b0;
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++; $display("FAIL midstream_count: count=%0d need 3", count);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (out_vld !== 1'b0 || count !== 3'd0 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL async_reset: vld=%b count=%0d ovf=%b drop=%0d need 0/0/0/0", out_vld, count, ovf, drop_cnt);
    end
    @(negedge clk);
    rst = 1'b1; out_rdy = 1'b1;
    in_ptr = 4'd7; in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_t1: out_vld=%b need 0", out_vld);
    end
    @(negedge clk);
    n_checks++;
    if (out_vld !== 1'b1 || out_ptr !== 4'd7 || out_data !== 8'hA7 || count !== 3'd1) begin
      n_fail++; $display("FAIL post_reset_t2: vld=%b ptr=%0d data=%h count=%0d need 1/7/a7/1", out_vld, out_ptr, out_data, count);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_overflow();
    test_full_push_pop();
    test_null_ptr();
    test_read_first();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
